flp_accumulator: RTL
====================

Name: flp_accumulator

Overview:
- Downstream consumer of the (exp, mant) FLP adder stage in the pseudo-softmax datapath.
- Sequentially accumulates a stream of `len` FLP terms into one FLP sum, which becomes the softmax denominator.
- Uses the same align / add / renormalize arithmetic as the adder, registered once per accepted element.
- Wraps the arithmetic in a start / valid-ready / done control FSM.

Parameters:
- EXP_WIDTH, 9, exponent width (unsigned).
- MANT_WIDTH, 8, mantissa width (unsigned, no hidden bit).
- CNT_WIDTH, 8, width of the element count.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse that begins an accumulation; sampled only in IDLE
- len  in  CNT_WIDTH  number of terms; sampled with start
- in_valid  in  1  input term valid
- in_ready  out  1  block accepts a term this cycle
- in_exp  in  EXP_WIDTH  term exponent
- in_mant  in  MANT_WIDTH  term mantissa
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_exp  out  EXP_WIDTH  accumulated exponent
- out_mant  out  MANT_WIDTH  accumulated mantissa
- busy  out  1  high whenever state is not IDLE
- sat  out  1  sticky exponent-saturation flag

Behaviour:
- Reset: while rst_n=0 at a clk edge, the block goes to
  - state IDLE, acc_exp=0, acc_mant=0, count=0, sat=0;
  - outputs in_ready=0, out_valid=0, busy=0.
- Reset asserted mid-operation abandons the run. There is no partial result.
- out_exp/out_mant are driven directly from acc_exp/acc_mant at all times. They are meaningful only while out_valid=1.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 and len!=0: acc <= (0,0), count <= len, sat <= 0, go to ACCUM.
  - start=1 and len==0: acc <= (0,0), sat <= 0, go directly to DONE. Result is (0,0).
- ACCUM:
  - in_ready=1 (combinational from state).
  - On in_valid & in_ready: acc <= acc (+) in, count <= count-1.
  - If count==1 at that accept, go to DONE.
  - in_valid=0 stalls indefinitely with no state change.
- DONE:
  - out_valid=1; out data is held stable.
  - On out_ready=1, go to IDLE.
  - out_valid therefore rises the cycle after the last accept.
- start is ignored outside IDLE. Throughput is one term per cycle.
- FLP add (+), operands A=acc and B=in:
  - d = |A.exp - B.exp|.
  - L = operand with the larger exponent (ties: L=A); S = the other.
  - Aligned value = S.mant >> d. If d >= MANT_WIDTH the aligned value is 0.
  - s = L.mant + aligned, computed in MANT_WIDTH+1 bits.
  - s[MANT_WIDTH]=0: result = (L.exp, s[MANT_WIDTH-1:0]).
  - s[MANT_WIDTH]=1 and L.exp < max: result = (L.exp+1, s[MANT_WIDTH:1]), truncating.
  - s[MANT_WIDTH]=1 and L.exp == all-ones: result = (all-ones, all-ones) and sat <= 1.
- sat is sticky until the next accepted start.

Optional Feature:
- Macro: FLP_ACC_MAXEXP_EN.
- Defined:
  - Extra port `out_max_exp` (out, EXP_WIDTH): the largest in_exp accepted in the current run.
  - Cleared to 0 on start and on reset; updated on each accept.
  - Valid alongside out_valid; it is used by the later normalization stage.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- len=2, terms (3,0x80), (3,0x80) -> out_valid=1 the cycle after the 2nd accept, result (4,0x80), sat=0.
- len=3, terms (5,0x40), (3,0x80), (5,0x10) -> result (5,0x70). With FLP_ACC_MAXEXP_EN, out_max_exp=5.
- len=2, terms (20,0xFF), (5,0xFF) -> d=15 >= 8, so the aligned value is 0 and the result is (20,0xFF).
- len=2, terms (511,0xFF), (511,0x01) -> result (511,0xFF), sat=1. sat clears on the next start.
- len=0 start -> result (0,0), out_valid the next cycle.
- Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid, out_exp and out_mant stable, in_ready=0, and a start pulse there is ignored.
- Reset mid-run: rst_n=0 for one cycle after 1 of 3 terms accepted, while in_valid=1 -> next cycle in_ready=0, out_valid=0, busy=0. A fresh len=1 run with term (7,0x33) then yields (7,0x33).

Source files
------------

// File: rtl/flp_accumulator.sv
// Sequential FLP accumulator: sums `len` (exp, mant) terms with align/add/renormalize.
// Optional FLP_ACC_MAXEXP_EN adds out_max_exp, the largest term exponent seen in the run.
module flp_accumulator #(
  parameter int unsigned EXP_WIDTH  = 9,
  parameter int unsigned MANT_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_WIDTH-1:0]  in_exp,
  input  logic [MANT_WIDTH-1:0] in_mant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_WIDTH-1:0]  out_exp,
  output logic [MANT_WIDTH-1:0] out_mant,
  output logic                  busy,
  output logic                  sat
`ifdef FLP_ACC_MAXEXP_EN
  ,
  output logic [EXP_WIDTH-1:0]  out_max_exp
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [EXP_WIDTH-1:0] EXP_ONE   = EXP_WIDTH'(1);
  localparam logic [EXP_WIDTH-1:0] MANT_W_E  = EXP_WIDTH'(MANT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t                  state;
  logic [EXP_WIDTH-1:0]    acc_exp;
  logic [MANT_WIDTH-1:0]   acc_mant;
  logic [CNT_WIDTH-1:0]    count;

  logic [EXP_WIDTH-1:0]    l_exp;
  logic [MANT_WIDTH-1:0]   l_mant;
  logic [MANT_WIDTH-1:0]   s_mant;
  logic [EXP_WIDTH-1:0]    d;
  logic [MANT_WIDTH-1:0]   aligned;
  logic [MANT_WIDTH:0]     sum;
  logic [EXP_WIDTH-1:0]    n_exp;
  logic [MANT_WIDTH-1:0]   n_mant;
  logic                    n_sat;

  // acc is operand A; on an exponent tie A stays the larger operand
  always_comb begin
    if (in_exp > acc_exp) begin
      l_exp  = in_exp;
      l_mant = in_mant;
      s_mant = acc_mant;
      d      = in_exp - acc_exp;
    end else begin
      l_exp  = acc_exp;
      l_mant = acc_mant;
      s_mant = in_mant;
      d      = acc_exp - in_exp;
    end
    aligned = (d >= MANT_W_E) ? '0 : (s_mant >> d);
    sum     = {1'b0, l_mant} + {1'b0, aligned};
    n_sat   = 1'b0;
    if (!sum[MANT_WIDTH]) begin
      n_exp  = l_exp;
      n_mant = sum[MANT_WIDTH-1:0];
    end else if (l_exp != '1) begin
      n_exp  = l_exp + EXP_ONE;
      n_mant = sum[MANT_WIDTH:1];
    end else begin
      n_exp  = '1;
      n_mant = '1;
      n_sat  = 1'b1;
    end
  end

`ifdef FLP_ACC_MAXEXP_EN
  logic [EXP_WIDTH-1:0] max_exp;
  assign out_max_exp = max_exp;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc_exp  <= '0;
      acc_mant <= '0;
      count    <= '0;
      sat      <= 1'b0;
`ifdef FLP_ACC_MAXEXP_EN
      max_exp  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_exp  <= '0;
            acc_mant <= '0;
            sat      <= 1'b0;
`ifdef FLP_ACC_MAXEXP_EN
            max_exp  <= '0;
`endif
            if (len != '0) begin
              count <= len;
              state <= ACCUM;
            end else begin
              state <= DONE;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_exp  <= n_exp;
            acc_mant <= n_mant;
            count    <= count - CNT_ONE;
            if (n_sat) sat <= 1'b1;
`ifdef FLP_ACC_MAXEXP_EN
            if (in_exp > max_exp) max_exp <= in_exp;
`endif
            if (count == CNT_ONE) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_exp   = acc_exp;
  assign out_mant  = acc_mant;

endmodule
